// File: rtl/img_pkg.sv
// Shared image-datapath defaults and the line-length clamp used when a new frame starts.
package img_pkg;

    localparam int unsigned DATA_W_DEF  = 8;
    localparam int unsigned MAX_LEN_DEF = 128;

    // A zero or oversized programmed length falls back to the full line.
    function automatic int unsigned clamp_len(input int unsigned len_in,
                                              input int unsigned max_len);
        return ((len_in == 0) || (len_in > max_len)) ? max_len : len_in;
    endfunction

endpackage

// File: rtl/line_delay.sv
// One line of pixel storage: synchronous-read RAM, read-before-write on a shared address.
// FWD=1 bypasses a same-address write into the read register (used by the delayed cascade stages).
module line_delay
    import img_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = MAX_LEN_DEF,
    parameter int unsigned AW     = $clog2(DEPTH),
    parameter bit          FWD    = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_re,
    input  logic [AW-1:0]     i_raddr,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;
    logic              w_fwd;

    assign w_fwd   = FWD && i_we && (i_waddr == i_raddr);
    assign o_rdata = r_rdata;

    // Storage array: no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= w_fwd ? i_wdata : r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/line_buffer_mt.sv
// Multi-tap line buffer: presents the current pixel plus the same column from the previous TAPS-1 lines.
// Cascade writes into stages j>0 are deferred to the next accepted pixel so every RAM keeps a registered read.
module line_buffer_mt
    import img_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned MAX_LEN = MAX_LEN_DEF,
    parameter int unsigned TAPS    = 3,
    parameter int unsigned LEN_W   = $clog2(MAX_LEN) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic [LEN_W-1:0]       line_len,
    input  logic                   en,
    input  logic [DATA_W-1:0]      data_in,
    output logic [TAPS*DATA_W-1:0] data_out,
    output logic [TAPS-1:0]        tap_valid,
    output logic                   out_stb,
    output logic [LEN_W-1:0]       col,
    output logic                   line_end
);

    localparam int unsigned AW   = $clog2(MAX_LEN);
    localparam int unsigned PC_W = $clog2((TAPS - 1) * MAX_LEN + 2);

    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_wp;
    logic [AW-1:0]     r_wp_prev;
    logic              r_wr_pend;
    logic [PC_W-1:0]   r_pc;
    logic [DATA_W-1:0] r_tap0;
    logic [TAPS-1:0]   r_tap_valid;
    logic              r_out_stb;
    logic [LEN_W-1:0]  r_col;
    logic              r_line_end;

    logic              w_acc;
    logic              w_wp_last;
    logic [AW-1:0]     w_addr;
    logic [PC_W-1:0]   w_pc_sat;
    logic [PC_W-1:0]   w_pc_nxt;
    logic [TAPS-1:0]   w_tv;
    logic [DATA_W-1:0] w_rd [TAPS-1];

    assign w_acc     = en && !clr;
    assign w_wp_last = (r_wp == r_len - LEN_W'(1));
    assign w_addr    = r_wp[AW-1:0];

    // Saturating push count and the per-tap validity it implies after this push.
    always_comb begin
        w_pc_sat = PC_W'(TAPS - 1) * PC_W'(r_len) + PC_W'(1);
        w_pc_nxt = (r_pc >= w_pc_sat) ? r_pc : r_pc + PC_W'(1);
        w_tv     = '0;
        for (int k = 0; k < int'(TAPS); k++) begin
            w_tv[k] = (w_pc_nxt >= PC_W'(k) * PC_W'(r_len) + PC_W'(1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len     <= LEN_W'(MAX_LEN);
            r_wp      <= '0;
            r_wp_prev <= '0;
            r_wr_pend <= 1'b0;
            r_pc      <= '0;
        end else if (clr) begin
            r_len     <= LEN_W'(clamp_len(32'(line_len), MAX_LEN));
            r_wp      <= '0;
            r_wr_pend <= 1'b0;
            r_pc      <= '0;
        end else if (w_acc) begin
            r_wp      <= w_wp_last ? '0 : r_wp + LEN_W'(1);
            r_wp_prev <= w_addr;
            r_wr_pend <= 1'b1;
            r_pc      <= w_pc_nxt;
        end
    end

    // Output register; the deeper taps are the RAM read registers themselves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tap0      <= '0;
            r_tap_valid <= '0;
            r_out_stb   <= 1'b0;
            r_col       <= '0;
            r_line_end  <= 1'b0;
        end else if (clr) begin
            r_tap_valid <= '0;
            r_out_stb   <= 1'b0;
            r_col       <= '0;
            r_line_end  <= 1'b0;
        end else if (w_acc) begin
            r_tap0      <= data_in;
            r_tap_valid <= w_tv;
            r_out_stb   <= 1'b1;
            r_col       <= r_wp;
            r_line_end  <= w_wp_last;
        end else begin
            r_out_stb   <= 1'b0;
            r_line_end  <= 1'b0;
        end
    end

    genvar j;
    generate
        for (j = 0; j < int'(TAPS) - 1; j++) begin : g_line
            if (j == 0) begin : g_first
                line_delay #(
                    .DATA_W (DATA_W),
                    .DEPTH  (MAX_LEN),
                    .AW     (AW),
                    .FWD    (1'b0)
                ) u_line (
                    .clk     (clk),
                    .rst     (rst),
                    .i_re    (w_acc),
                    .i_raddr (w_addr),
                    .i_we    (w_acc),
                    .i_waddr (w_addr),
                    .i_wdata (data_in),
                    .o_rdata (w_rd[j])
                );
            end else begin : g_next
                // Writes what the previous stage read on the last accepted pixel, at that pixel's address.
                line_delay #(
                    .DATA_W (DATA_W),
                    .DEPTH  (MAX_LEN),
                    .AW     (AW),
                    .FWD    (1'b1)
                ) u_line (
                    .clk     (clk),
                    .rst     (rst),
                    .i_re    (w_acc),
                    .i_raddr (w_addr),
                    .i_we    (w_acc && r_wr_pend),
                    .i_waddr (r_wp_prev),
                    .i_wdata (w_rd[j-1]),
                    .o_rdata (w_rd[j])
                );
            end
            assign data_out[(j+1)*DATA_W +: DATA_W] = w_rd[j];
        end
    endgenerate

    assign data_out[0 +: DATA_W] = r_tap0;
    assign tap_valid = r_tap_valid;
    assign out_stb   = r_out_stb;
    assign col       = r_col;
    assign line_end  = r_line_end;

endmodule

// File: tb/tb_line_buffer_mt.sv
// Directed bench for line_buffer_mt with TAPS=3, DATA_W=8, MAX_LEN=128.
module tb_line_buffer_mt;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned MAX_LEN = 128;
    localparam int unsigned TAPS    = 3;
    localparam int unsigned LEN_W   = 8;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   clr;
    logic [LEN_W-1:0]       line_len;
    logic                   en;
    logic [DATA_W-1:0]      data_in;
    logic [TAPS*DATA_W-1:0] data_out;
    logic [TAPS-1:0]        tap_valid;
    logic                   out_stb;
    logic [LEN_W-1:0]       col;
    logic                   line_end;

    int n_chk  = 0;
    int n_fail = 0;

    line_buffer_mt #(
        .DATA_W  (DATA_W),
        .MAX_LEN (MAX_LEN),
        .TAPS    (TAPS),
        .LEN_W   (LEN_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .line_len  (line_len),
        .en        (en),
        .data_in   (data_in),
        .data_out  (data_out),
        .tap_valid (tap_valid),
        .out_stb   (out_stb),
        .col       (col),
        .line_end  (line_end)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: inputs applied at the falling edge, outputs sampled 1 time unit after the rising edge.
    task automatic step(input logic c, input logic e, input logic [7:0] d, input logic [7:0] ll);
        @(negedge clk);
        clr      = c;
        en       = e;
        data_in  = d;
        line_len = ll;
        @(posedge clk);
        #1;
        clr = 1'b0;
        en  = 1'b0;
    endtask

    function automatic logic [7:0] tap(input logic [23:0] v, input int k);
        return v[k*8 +: 8];
    endfunction

    // Expected response to the i-th pixel (value i) of a len=4 frame.
    task automatic chk_len4(input int i);
        logic [2:0] tv;
        tv = (i >= 9) ? 3'b111 : (i >= 5) ? 3'b011 : 3'b001;
        chk($sformatf("l4_stb_%0d", i), 32'(out_stb), 32'd1);
        chk($sformatf("l4_tv_%0d", i), 32'(tap_valid), 32'(tv));
        chk($sformatf("l4_col_%0d", i), 32'(col), 32'((i - 1) % 4));
        chk($sformatf("l4_le_%0d", i), 32'(line_end), 32'(i % 4 == 0));
        for (int k = 0; k < 3; k++) begin
            if (tv[k]) chk($sformatf("l4_tap%0d_%0d", k, i), 32'(tap(data_out, k)), 32'(i - 4 * k));
        end
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; en = 1'b0; data_in = '0; line_len = '0;
        #12;
        chk("rst_dout", 32'(data_out), 32'd0);
        chk("rst_tv",   32'(tap_valid), 32'd0);
        chk("rst_stb",  32'(out_stb), 32'd0);
        chk("rst_col",  32'(col), 32'd0);
        chk("rst_le",   32'(line_end), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // len=4, pixels 1..12 back-to-back
        step(1'b1, 1'b0, 8'd0, 8'd4);
        for (int i = 1; i <= 12; i++) begin
            step(1'b0, 1'b1, 8'(i), 8'd4);
            chk_len4(i);
        end
        chk("l4_dout_final", 32'(data_out), 32'h04080C);

        // Same stream with en toggled: identical taps, held outputs on idle cycles
        step(1'b1, 1'b0, 8'd0, 8'd4);
        for (int i = 1; i <= 12; i++) begin
            step(1'b0, 1'b1, 8'(i), 8'd4);
            chk_len4(i);
            step(1'b0, 1'b0, 8'hEE, 8'd4);
            chk($sformatf("tg_stb_%0d", i), 32'(out_stb), 32'd0);
            chk($sformatf("tg_le_%0d", i), 32'(line_end), 32'd0);
            chk($sformatf("tg_col_%0d", i), 32'(col), 32'((i - 1) % 4));
            chk($sformatf("tg_tap0_%0d", i), 32'(tap(data_out, 0)), 32'(i));
            chk($sformatf("tg_tv_%0d", i), 32'(tap_valid),
                (i >= 9) ? 32'd7 : (i >= 5) ? 32'd3 : 32'd1);
        end
        chk("tg_dout_final", 32'(data_out), 32'h04080C);

        // line_len 0 and 200 both clamp to 128
        for (int t = 0; t < 2; t++) begin
            logic [7:0] ll;
            logic [7:0] base;
            ll   = (t == 0) ? 8'd0 : 8'd200;
            base = (t == 0) ? 8'd0 : 8'd50;
            step(1'b1, 1'b0, 8'd0, ll);
            for (int i = 1; i <= 129; i++) begin
                step(1'b0, 1'b1, 8'(i) + base, ll);
                if (i == 128) begin
                    chk($sformatf("cl%0d_tv128", t), 32'(tap_valid), 32'd1);
                    chk($sformatf("cl%0d_col128", t), 32'(col), 32'd127);
                    chk($sformatf("cl%0d_le128", t), 32'(line_end), 32'd1);
                end
            end
            chk($sformatf("cl%0d_tv129", t), 32'(tap_valid), 32'd3);
            chk($sformatf("cl%0d_col129", t), 32'(col), 32'd0);
            chk($sformatf("cl%0d_tap1", t), 32'(tap(data_out, 1)), 32'(8'd1 + base));
        end

        // clr together with en after 7 pixels, new len=2
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 8'(10 + i), 8'd0);
        step(1'b1, 1'b1, 8'd99, 8'd2);
        chk("clr_stb", 32'(out_stb), 32'd0);
        chk("clr_tv",  32'(tap_valid), 32'd0);
        chk("clr_col", 32'(col), 32'd0);
        chk("clr_le",  32'(line_end), 32'd0);
        step(1'b0, 1'b1, 8'd100, 8'd0);
        chk("clr_p100_col", 32'(col), 32'd0);
        chk("clr_p100_tv",  32'(tap_valid), 32'd1);
        chk("clr_p100_tap0", 32'(tap(data_out, 0)), 32'd100);
        step(1'b0, 1'b1, 8'd101, 8'd0);
        chk("clr_p101_col", 32'(col), 32'd1);
        chk("clr_p101_le",  32'(line_end), 32'd1);
        step(1'b0, 1'b1, 8'd102, 8'd0);
        chk("clr_p102_tv",   32'(tap_valid), 32'd3);
        chk("clr_p102_tap1", 32'(tap(data_out, 1)), 32'd100);
        chk("clr_p102_col",  32'(col), 32'd0);

        // Async reset with wp=3 in a len=4 frame
        step(1'b1, 1'b0, 8'd0, 8'd4);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'(30 + i), 8'd0);
        chk("ar_pre_col", 32'(col), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_dout", 32'(data_out), 32'd0);
        chk("ar_tv",   32'(tap_valid), 32'd0);
        chk("ar_col",  32'(col), 32'd0);
        chk("ar_stb",  32'(out_stb), 32'd0);
        chk("ar_le",   32'(line_end), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 1'b1, 8'd77, 8'd0);
        chk("ar_p_col",  32'(col), 32'd0);
        chk("ar_p_tv",   32'(tap_valid), 32'd1);
        chk("ar_p_tap0", 32'(tap(data_out, 0)), 32'd77);
        chk("ar_p_stb",  32'(out_stb), 32'd1);

        // len=1, pixels 5,6,7
        step(1'b1, 1'b0, 8'd0, 8'd1);
        step(1'b0, 1'b1, 8'd5, 8'd0);
        chk("l1_tv5", 32'(tap_valid), 32'd1);
        chk("l1_le5", 32'(line_end), 32'd1);
        step(1'b0, 1'b1, 8'd6, 8'd0);
        chk("l1_tv6",   32'(tap_valid), 32'd3);
        chk("l1_tap1_6", 32'(tap(data_out, 1)), 32'd5);
        step(1'b0, 1'b1, 8'd7, 8'd0);
        chk("l1_tv7",   32'(tap_valid), 32'd7);
        chk("l1_dout7", 32'(data_out), 32'h050607);
        chk("l1_col7",  32'(col), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
